// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage data-memory access unit of the 5-stage MIPS pipeline. It sits
// between the EX/MEM register outputs and the MEM/WB register, runs one
// req/ack transaction on the data-memory bus per load or store, and freezes the
// pipeline (stall_m) while that transaction is outstanding.
//
// Stores: byte enables and lane-replicated write data are built from
// mem_size_m and the low address bits (little-endian, lane = aluout_m[1:0]).
// Loads: the bus word is captured on the ack cycle. The selected byte, half or
// word is then sign- or zero-extended onto readdata_m during the DONE cycle.
// At all other times readdata_m holds the last extracted value.
//
// Optional build macro: MEM_ALIGN_EXC_EN
//   defined   : adds addr_exc_m. A misaligned half/word access raises it and
//               issues no request.
//   undefined : misaligned half/word accesses use the aligned-down lane.
//
// Ports
//   clk, reset            pipeline clock, synchronous active-high reset
//   memread_m/memwrite_m  load / store in M stage
//   mem_size_m            00 byte, 01 half, 1x word
//   mem_unsigned_m        zero-extend loads (lbu/lhu)
//   flush_m               kill the current M-stage instruction
//   aluout_m              effective byte address
//   writedata_m           store source register
//   dmem_*                data-memory bus (req/we/addr/be/wdata out, rdata/ack in)
//   readdata_m            extended load data to MEM/WB
//   addr_exc_m            misaligned access (only with MEM_ALIGN_EXC_EN)
//   stall_m               freeze PC, IF/ID, ID/EX, EX/MEM
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [31:0] RDATA_RESET = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memread_m,
  input  logic                  memwrite_m,
  input  logic [1:0]            mem_size_m,
  input  logic                  mem_unsigned_m,
  input  logic                  flush_m,
  input  logic [31:0]           aluout_m,
  input  logic [31:0]           writedata_m,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic [31:0]           readdata_m,
`ifdef MEM_ALIGN_EXC_EN
  output logic                  addr_exc_m,
`endif
  output logic                  stall_m
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        flushed_q, flushed_d;  // flush seen while BUSY; drop the DONE
  logic [31:0] rdata_q;               // raw bus word of the last load
  logic [31:0] hold_q;                // last value shown on readdata_m

  logic [1:0]  lane;
  logic        is_mem;
  logic        is_byte;
  logic        is_half;
  logic        pending;
  logic        capture;
  logic        load_done;
  logic [31:0] load_ext;

  assign lane    = aluout_m[1:0];
  assign is_mem  = memread_m | memwrite_m;
  assign is_byte = (mem_size_m == 2'b00);
  assign is_half = (mem_size_m == 2'b01);

`ifdef MEM_ALIGN_EXC_EN
  // Word is size 10 or 11; anything not byte/half is a word access.
  assign addr_exc_m = is_mem & ((is_half & lane[0]) |
                                (~is_byte & ~is_half & (lane != 2'b00)));
  assign pending    = is_mem & ~flush_m & ~addr_exc_m;
`else
  assign pending    = is_mem & ~flush_m;
`endif

  // ---------------------------------------------------------------------------
  // Bus formatting. Address, enables and data follow the M inputs directly;
  // upstream holds them stable for as long as stall_m is high.
  // ---------------------------------------------------------------------------
  assign dmem_we   = memwrite_m;
  assign dmem_addr = {aluout_m[ADDR_WIDTH-1:2], 2'b00};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = writedata_m;
    if (is_byte) begin
      dmem_be    = 4'b0001 << lane;
      dmem_wdata = {4{writedata_m[7:0]}};
    end else if (is_half) begin
      // lane[0] is ignored: a misaligned half falls back to its aligned half.
      dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{writedata_m[15:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Access FSM
  //   IDLE -> BUSY on a pending access; IDLE -> DONE if ack arrives at once.
  //   BUSY -> DONE on ack, or -> IDLE on ack if the instruction was flushed.
  //   DONE -> IDLE always. DONE is the only cycle with stall_m low during an access.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    flushed_d = flushed_q;
    capture   = 1'b0;
    dmem_req  = 1'b0;
    stall_m   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        flushed_d = 1'b0;
        // An ack with nothing pending is stale (e.g. abandoned by reset).
        if (pending) begin
          dmem_req = 1'b1;
          stall_m  = 1'b1;
          if (dmem_ack) begin
            state_d = ST_DONE;
            capture = memread_m;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // The bus transaction cannot be cancelled, so it runs to ack even
        // when flushed. The flush is remembered in case it is only a pulse.
        dmem_req = 1'b1;
        stall_m  = 1'b1;
        if (flush_m) begin
          flushed_d = 1'b1;
        end
        if (dmem_ack) begin
          flushed_d = 1'b0;
          if (flush_m | flushed_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            capture = memread_m;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the captured word. The M inputs are still those of
  // the completing instruction during DONE, so lane/size/sign are taken live.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ext = rdata_q;
    if (is_byte) begin
      unique case (lane)
        2'd0: load_ext = {{24{rdata_q[7]  & ~mem_unsigned_m}}, rdata_q[7:0]};
        2'd1: load_ext = {{24{rdata_q[15] & ~mem_unsigned_m}}, rdata_q[15:8]};
        2'd2: load_ext = {{24{rdata_q[23] & ~mem_unsigned_m}}, rdata_q[23:16]};
        default: load_ext = {{24{rdata_q[31] & ~mem_unsigned_m}}, rdata_q[31:24]};
      endcase
    end else if (is_half) begin
      if (lane[1]) begin
        load_ext = {{16{rdata_q[31] & ~mem_unsigned_m}}, rdata_q[31:16]};
      end else begin
        load_ext = {{16{rdata_q[15] & ~mem_unsigned_m}}, rdata_q[15:0]};
      end
    end
  end

  // A store's DONE cycle must not disturb readdata_m.
  assign load_done  = (state_q == ST_DONE) & memread_m;
  assign readdata_m = load_done ? load_ext : hold_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      flushed_q <= 1'b0;
      rdata_q   <= RDATA_RESET;
      hold_q    <= RDATA_RESET;
    end else begin
      state_q   <= state_d;
      flushed_q <= flushed_d;
      if (capture) begin
        rdata_q <= dmem_rdata;
      end
      if (load_done) begin
        hold_q <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. Each access pushes its expected
// readdata_m and stall count onto a scoreboard queue when it is driven. The
// entry is popped and compared when the DUT reaches its DONE cycle (stall_m low).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam logic [31:0] RDATA_RESET = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread_m;
  logic        memwrite_m;
  logic [1:0]  mem_size_m;
  logic        mem_unsigned_m;
  logic        flush_m;
  logic [31:0] aluout_m;
  logic [31:0] writedata_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] readdata_m;
  logic        stall_m;
`ifdef MEM_ALIGN_EXC_EN
  logic        addr_exc_m;
`endif

  mem_access_unit #(
    .ADDR_WIDTH (32),
    .RDATA_RESET(RDATA_RESET)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .memread_m     (memread_m),
    .memwrite_m    (memwrite_m),
    .mem_size_m    (mem_size_m),
    .mem_unsigned_m(mem_unsigned_m),
    .flush_m       (flush_m),
    .aluout_m      (aluout_m),
    .writedata_m   (writedata_m),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .readdata_m    (readdata_m),
`ifdef MEM_ALIGN_EXC_EN
    .addr_exc_m    (addr_exc_m),
`endif
    .stall_m       (stall_m)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rd;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd;

  // Reference load extraction, written as shifts rather than lane muxes.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] ln);
    logic [31:0] s;
    if (sz == 2'b00) begin
      s = (w >> (8 * ln)) & 32'h0000_00FF;
      if (!uns && s[7]) s = s | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      s = (w >> (16 * ln[1])) & 32'h0000_FFFF;
      if (!uns && s[15]) s = s | 32'hFFFF_0000;
    end else begin
      s = w;
    end
    return s;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] ln);
    if (sz == 2'b00) return 4'(1 << ln);
    if (sz == 2'b01) return ln[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {4{wd[7:0]}};
    if (sz == 2'b01) return {2{wd[15:0]}};
    return wd;
  endfunction

  // Runs one access from the cycle it is presented until DONE. Called 1 ns
  // after a rising edge and returns 1 ns after a rising edge.
  // ack_delay = number of request cycles before the one carrying ack.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int ack_delay,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rd);
    exp_t e;
    int   stalls = 0;
    bit   done   = 1'b0;
    e.tag = tag; e.rd = exp_rd; e.stalls = ack_delay + 1;
    sb_q.push_back(e);
    memread_m = rd; memwrite_m = wr; mem_size_m = sz; mem_unsigned_m = uns;
    flush_m = 1'b0; aluout_m = addr; writedata_m = wdata;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      dmem_ack   = (cyc == ack_delay);
      dmem_rdata = (cyc == ack_delay) ? rdata : ~rdata;
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, ":req"},  32'(dmem_req), 32'd1);
        check({tag, ":we"},   32'(dmem_we), 32'(wr));
        check({tag, ":addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, ":be"},   32'(dmem_be), 32'(exp_be));
        if (wr) check({tag, ":wdata"}, dmem_wdata, exp_wdata);
      end
      if (stall_m) begin
        stalls++;
      end else begin
        done = 1'b1;
        e = sb_q.pop_front();
        check({e.tag, ":readdata"}, readdata_m, e.rd);
        check({e.tag, ":stalls"}, 32'(stalls), 32'(e.stalls));
        check({e.tag, ":req_done"}, 32'(dmem_req), 32'd0);
      end
      @(posedge clk); #1;
    end
    check({tag, ":completed"}, 32'(done), 32'd1);
    memread_m = 1'b0; memwrite_m = 1'b0; dmem_ack = 1'b0;
    last_rd = exp_rd;
  endtask

  initial begin
    logic [31:0] prev;
    reset = 1'b1; memread_m = 1'b0; memwrite_m = 1'b0; mem_size_m = 2'b10;
    mem_unsigned_m = 1'b0; flush_m = 1'b0; aluout_m = '0; writedata_m = '0;
    dmem_rdata = '0; dmem_ack = 1'b0; last_rd = RDATA_RESET;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst:req",      32'(dmem_req), 32'd0);
    check("rst:stall",    32'(stall_m), 32'd0);
    check("rst:readdata", readdata_m, RDATA_RESET);
    @(posedge clk); #1;

    // Directed accesses.
    run_access("lw100",  1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               4'hF, 32'h0, 32'hDEADBEEF);
    run_access("lb103",  1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF7F01, 3,
               4'h8, 32'h0, 32'hFFFFFF80);
    run_access("lbu103", 1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF7F01, 3,
               4'h8, 32'h0, 32'h00000080);
    run_access("sh202",  0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'h0, 1,
               4'hC, 32'hABCDABCD, last_rd);
    run_access("lh102",  1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h80FF7F01, 2,
               4'hC, 32'h0, 32'hFFFF80FF);
    run_access("lhu100", 1, 0, 2'b01, 1, 32'h100, 32'h0, 32'h80FF7F01, 0,
               4'h3, 32'h0, 32'h00007F01);
    run_access("sb206",  0, 1, 2'b00, 0, 32'h206, 32'h000000A5, 32'h0, 0,
               4'h4, 32'hA5A5A5A5, last_rd);

    // Misaligned word access.
`ifdef MEM_ALIGN_EXC_EN
    memread_m = 1'b1; mem_size_m = 2'b10; aluout_m = 32'h101;
    @(negedge clk);
    check("mis:exc",   32'(addr_exc_m), 32'd1);
    check("mis:req",   32'(dmem_req), 32'd0);
    check("mis:stall", 32'(stall_m), 32'd0);
    check("mis:rd",    readdata_m, last_rd);
    @(posedge clk); #1 memread_m = 1'b0;
`else
    run_access("lw101", 1, 0, 2'b10, 0, 32'h101, 32'h0, 32'hCAFEF00D, 1,
               4'hF, 32'h0, 32'hCAFEF00D);
`endif

    // Flush while BUSY: bus runs to ack, no DONE, readdata_m unchanged.
    prev = last_rd;
    memread_m = 1'b1; mem_size_m = 2'b10; mem_unsigned_m = 1'b0; aluout_m = 32'h300;
    @(negedge clk); check("fl:stall0", 32'(stall_m), 32'd1);
    @(posedge clk); #1 flush_m = 1'b1;
    @(negedge clk); check("fl:stall1", 32'(stall_m), 32'd1);
    @(posedge clk); #1 flush_m = 1'b0;
    @(negedge clk); check("fl:stall2", 32'(stall_m), 32'd1);
    @(posedge clk); #1 dmem_ack = 1'b1; dmem_rdata = 32'h5555AAAA;
    @(negedge clk); check("fl:stall_ack", 32'(stall_m), 32'd1);
    check("fl:req_ack", 32'(dmem_req), 32'd1);
    // Instruction stays killed; a DONE here would expose the new word.
    @(posedge clk); #1 dmem_ack = 1'b0; flush_m = 1'b1;
    @(negedge clk);
    check("fl:stall_after", 32'(stall_m), 32'd0);
    check("fl:req_after",   32'(dmem_req), 32'd0);
    check("fl:readdata",    readdata_m, prev);
    @(posedge clk); #1 memread_m = 1'b0; flush_m = 1'b0;

    // Back-to-back random aligned accesses through the reference model.
    for (int i = 0; i < 12; i++) begin
      logic        rd;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdw;
      int          dly;
      rd   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 2));
      uns  = 1'($urandom_range(0, 1));
      addr = {20'h0, 10'($urandom), 2'($urandom)};
      if (sz == 2'b01) addr[0] = 1'b0;
      if (sz == 2'b10) addr[1:0] = 2'b00;
      wd   = $urandom;
      rdw  = $urandom;
      dly  = $urandom_range(0, 3);
      run_access($sformatf("rnd%0d", i), rd, ~rd, sz, uns, addr, wd, rdw, dly,
                 ref_be(sz, addr[1:0]), ref_wdata(sz, wd),
                 rd ? ref_load(rdw, sz, uns, addr[1:0]) : last_rd);
    end

    // Make sure readdata_m is away from the reset value before testing reset.
    run_access("lw_pre", 1, 0, 2'b10, 0, 32'h500, 32'h0, 32'h13579BDF, 0,
               4'hF, 32'h0, 32'h13579BDF);

    // Reset while BUSY, followed by a late ack.
    memread_m = 1'b1; mem_size_m = 2'b10; aluout_m = 32'h400;
    @(negedge clk); check("rb:req_idle", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); check("rb:req_busy", 32'(dmem_req), 32'd1);
    @(posedge clk); #1 reset = 1'b1; memread_m = 1'b0;
    @(negedge clk); check("rb:req_rst", 32'(dmem_req), 32'd1);
    @(posedge clk); #1 reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    check("rb:req_after", 32'(dmem_req), 32'd0);
    check("rb:stall",     32'(stall_m), 32'd0);
    check("rb:readdata",  readdata_m, RDATA_RESET);
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    check("rb:req_late",  32'(dmem_req), 32'd0);
    check("rb:rd_late",   readdata_m, RDATA_RESET);
    @(posedge clk); #1;
    last_rd = RDATA_RESET;

    // Normal operation after reset.
    run_access("lw_post", 1, 0, 2'b10, 0, 32'h600, 32'h0, 32'h0BADF00D, 1,
               4'hF, 32'h0, 32'h0BADF00D);

    check("sb:empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage data-memory access unit of the 5-stage MIPS pipeline; sits between EX/MEM register outputs and the MEM/WB register.
- Drives a req/ack data-memory bus. Generates byte enables and lane-replicated store data. Extracts and sign/zero-extends load data into readdata_m.
- Asserts stall_m for the whole pipeline while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of dmem_addr. Byte address taken from aluout_m[ADDR_WIDTH-1:0].
- RDATA_RESET, 32'h0, reset value of the load-data holding register.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- memread_m  in  1  load in M stage
- memwrite_m  in  1  store in M stage
- mem_size_m  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned_m  in  1  1 = zero-extend load (lbu/lhu)
- flush_m  in  1  kill current M-stage instruction
- aluout_m  in  32  effective byte address
- writedata_m  in  32  store source register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits forced 0
- dmem_be  out  4  byte enables, bit i = byte lane i
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  access complete, single-cycle pulse
- readdata_m  out  32  extended load data to MEM/WB
- stall_m  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble not inserted

Behaviour:
- Little-endian. lane = aluout_m[1:0].
- pending = (memread_m | memwrite_m) & ~flush_m.
- FSM states:
  - IDLE: if pending, go to BUSY. Bus signals are driven combinationally this cycle.
  - BUSY: go to DONE on dmem_ack; otherwise stay in BUSY.
  - DONE: go to IDLE unconditionally.
- Bus signals:
  - dmem_req = (IDLE & pending) | BUSY.
  - dmem_we, dmem_addr, dmem_be, dmem_wdata are derived combinationally from the M inputs.
  - Upstream holds the M inputs stable while stall_m = 1.
- dmem_ack in IDLE is ignored. An ack may arrive in the first cycle the request is asserted; the FSM then goes IDLE→DONE directly.
- stall_m = (IDLE & pending) | BUSY, i.e. deasserted only in DONE.
- Latency: an access costs (cycles from first dmem_req to dmem_ack, inclusive) + 1. The minimum is 2 cycles, of which 1 is a stall.
- Store formatting:
  - byte: be = 4'b0001 << lane, wdata = {4{writedata_m[7:0]}}
  - half: be = lane[1] ? 4'b1100 : 4'b0011, wdata = {2{writedata_m[15:0]}}
  - word: be = 4'b1111, wdata = writedata_m
- Loads:
  - dmem_rdata is captured into rdata_q on the ack cycle.
  - readdata_m selects the byte/half/word from rdata_q by lane and size. It is sign-extended unless mem_unsigned_m = 1.
  - readdata_m is valid in DONE. Otherwise it holds the last extracted value.
  - Stores do not update rdata_q.
- flush_m:
  - In IDLE: suppresses the request entirely.
  - In BUSY: the bus transaction runs to ack. The FSM then goes to IDLE instead of DONE, and stall_m stays high until ack.
- Non-memory instructions: no request, stall_m = 0, readdata_m unchanged.
- Reset (any state, including BUSY):
  - state = IDLE, rdata_q = RDATA_RESET.
  - dmem_req drops next cycle.
  - The memory must tolerate an abandoned request; a late ack is ignored in IDLE.
- Back-to-back memory instructions:
  - DONE→IDLE costs no extra bubble beyond the DONE cycle.
  - The next instruction's request starts in the IDLE cycle after DONE.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - Adds output addr_exc_m (1 bit), combinational.
  - Asserted when a half access has aluout_m[0] = 1, or a word access has aluout_m[1:0] ≠ 0, with memread_m | memwrite_m.
  - When asserted, pending = 0: no request, no stall, readdata_m unchanged.
- Not defined:
  - No addr_exc_m port.
  - Misaligned half/word accesses use the aligned-down lane (half: lane[1]; word: lane ignored) and proceed normally.

Test Plan:
- Reset, then lw at 0x100 with ack on the first request cycle and rdata 0xDEADBEEF → exactly 1 stall cycle; readdata_m = 0xDEADBEEF in DONE; dmem_be = 4'hF; dmem_addr = 0x100.
- lb at 0x103 with rdata 0x80FF7F01, ack after 3 wait cycles → stall 4 cycles; readdata_m = 0xFFFFFF80. Repeat as lbu → 0x00000080.
- sh at 0x202 with writedata 0x1234ABCD → dmem_we = 1, be = 4'b1100, wdata = 0xABCDABCD; stall released the cycle after ack.
- lw issued, flush_m asserted in BUSY, ack 2 cycles later → stall held until ack, no DONE, readdata_m unchanged.
- reset asserted in BUSY, then an ack pulse arrives → state IDLE, dmem_req = 0 the next cycle, readdata_m = RDATA_RESET, late ack ignored.
- With MEM_ALIGN_EXC_EN: lw at 0x101 → addr_exc_m = 1, dmem_req = 0, stall_m = 0. Without it: request issued with be = 4'hF, addr = 0x100.
